// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's read/write ports among
// NUM_CLIENTS requesters, one transaction in flight, with a watchdog abort.
module sdram_port_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_CLIENTS-1:0]    c_req,
    input  logic [NUM_CLIENTS-1:0]    c_we,
    input  logic [24*NUM_CLIENTS-1:0] c_adr,
    input  logic [16*NUM_CLIENTS-1:0] c_wdata,
    output logic [NUM_CLIENTS-1:0]    c_gnt,
    output logic [NUM_CLIENTS-1:0]    c_done,
    output logic                      c_err,
    output logic [15:0]               c_rdata,
    output logic                      rd_i_stb,
    input  logic                      rd_i_ack,
    input  logic                      rd_o_stb,
    output logic                      rd_o_ack,
    output logic [23:0]               RD_ADR,
    input  logic [15:0]               RD_DATA,
    output logic                      wt_i_stb,
    input  logic                      wt_i_ack,
    input  logic                      wt_o_stb,
    output logic                      wt_o_ack,
    output logic [23:0]               WT_ADR,
    output logic [15:0]               WT_DATA
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        ptr, idx, win, cand;
    logic [SUM_W-1:0]        sum;
    logic                    found;
    logic [NUM_CLIENTS-1:0]  win_oh, idx_oh;
    logic                    we_l;
    logic [23:0]             adr_l;
    logic [15:0]             wdata_l;
    logic [TO_W-1:0]         wdog;
    logic                    grant, accepted, complete, expired, abort;

    // Completion pulses are acknowledged unconditionally so the controller never stalls.
    assign rd_o_ack = rd_o_stb;
    assign wt_o_ack = wt_o_stb;
    assign RD_ADR   = adr_l;
    assign WT_ADR   = adr_l;
    assign WT_DATA  = wdata_l;

    always_comb begin
        win   = ptr;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_CLIENTS))
                sum = sum - SUM_W'(NUM_CLIENTS);
            cand = sum[IDX_W-1:0];
            if (!found && c_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_oh = '0;
        idx_oh = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            win_oh[i] = (win == IDX_W'(i));
            idx_oh[i] = (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (grant) state_nx = S_ISSUE;
            S_ISSUE: begin
                if (expired)       state_nx = S_IDLE;
                else if (accepted) state_nx = S_WAIT;
            end
            S_WAIT:  if (complete || expired) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // A completion landing in the same cycle as the watchdog expiry wins over the abort.
    always_comb begin
        grant    = 1'b0;
        accepted = 1'b0;
        complete = 1'b0;
        expired  = 1'b0;
        case (state)
            S_IDLE:  grant = found;
            S_ISSUE: begin
                expired  = (wdog == TO_W'(TIMEOUT));
                accepted = !expired && (we_l ? wt_i_ack : rd_i_ack);
            end
            S_WAIT:  begin
                expired  = (wdog == TO_W'(TIMEOUT));
                complete = we_l ? wt_o_stb : rd_o_stb;
            end
            default: ;
        endcase
    end
    assign abort = expired && !complete;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr      <= IDX_W'(NUM_CLIENTS - 1);
            idx      <= '0;
            we_l     <= 1'b0;
            adr_l    <= '0;
            wdata_l  <= '0;
            wdog     <= '0;
            c_gnt    <= '0;
            c_done   <= '0;
            c_err    <= 1'b0;
            c_rdata  <= '0;
            rd_i_stb <= 1'b0;
            wt_i_stb <= 1'b0;
        end else begin
            c_gnt  <= '0;
            c_done <= '0;
            c_err  <= 1'b0;
            if (state != S_IDLE)
                wdog <= wdog + TO_W'(1);
            if (grant) begin
                ptr      <= win;
                idx      <= win;
                we_l     <= c_we[win];
                adr_l    <= c_adr[int'(win)*24 +: 24];
                wdata_l  <= c_wdata[int'(win)*16 +: 16];
                c_gnt    <= win_oh;
                wdog     <= '0;
                wt_i_stb <= c_we[win];
                rd_i_stb <= !c_we[win];
            end
            if (accepted) begin
                wt_i_stb <= 1'b0;
                rd_i_stb <= 1'b0;
            end
            if (complete) begin
                c_done <= idx_oh;
                if (!we_l)
                    c_rdata <= RD_DATA;
            end
            if (abort) begin
                wt_i_stb <= 1'b0;
                rd_i_stb <= 1'b0;
                c_done   <= idx_oh;
                c_err    <= 1'b1;
                c_rdata  <= '0;
            end
        end
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the SDRAM controller's read and write request ports among NUM_CLIENTS requesters using round-robin arbitration.
- Holds one transaction in flight at a time. It drives the controller's stb/ack handshakes and returns read data and completion to the owning client.
- A watchdog aborts any transaction the controller does not finish in time.
- Sits between the system masters (video fetch, CPU bridge, DMA) and the SDRAM controller.

Parameters:
- NUM_CLIENTS, 3, number of requesters (2..8).
- TIMEOUT, 255, max cycles from ISSUE entry to completion before abort (1..2^TO_W-1).
- TO_W, 8, watchdog counter width.

Ports:
- CLK  in  1  system clock, same as the SDRAM controller.
- RST  in  1  synchronous, active-high reset.
- c_req  in  NUM_CLIENTS  per-client request level, held until c_gnt.
- c_we  in  NUM_CLIENTS  per-client 1=write, 0=read.
- c_adr  in  24*NUM_CLIENTS  per-client address {bank[23:22], row[21:9], col[8:0]}; client i uses slice [24i+23:24i].
- c_wdata  in  16*NUM_CLIENTS  per-client write data; client i uses slice [16i+15:16i].
- c_gnt  out  NUM_CLIENTS  one-hot, 1-cycle pulse: request latched.
- c_done  out  NUM_CLIENTS  one-hot, 1-cycle pulse: transaction finished.
- c_err  out  1  high with c_done when the transaction was aborted by timeout.
- c_rdata  out  16  read data, valid while c_done is high for a read.
- rd_i_stb  out  1  read request to controller.
- rd_i_ack  in  1  controller accepted read.
- rd_o_stb  in  1  read data valid pulse.
- rd_o_ack  out  1  read data acknowledge.
- RD_ADR  out  24  read address.
- RD_DATA  in  16  read data.
- wt_i_stb  out  1  write request to controller.
- wt_i_ack  in  1  controller accepted write.
- wt_o_stb  in  1  write complete pulse.
- wt_o_ack  out  1  write complete acknowledge.
- WT_ADR  out  24  write address.
- WT_DATA  out  16  write data.

Behaviour:
- **Reset (sync, RST high at posedge):**
  - State goes to IDLE and the round-robin pointer goes to NUM_CLIENTS-1, so client 0 has first priority.
  - Watchdog is cleared.
  - rd_i_stb, wt_i_stb, c_gnt, c_done and c_err are 0.
  - c_rdata, RD_ADR, WT_ADR and WT_DATA are 0.
  - Reset mid-transaction drops the stb immediately and does not pulse c_done.
- **Acknowledges:** rd_o_ack = rd_o_stb and wt_o_ack = wt_o_stb, combinationally, in every state. The controller is never stalled.
- **IDLE:**
  - If any c_req bit is set, grant the first set bit searching upward from pointer+1 with wrap-around (modulo NUM_CLIENTS).
  - On grant: latch the index, c_we, c_adr and c_wdata of the winner; update pointer := winner; pulse c_gnt[winner] next cycle; go to ISSUE.
  - Grant-to-ISSUE latency is 1 cycle after c_req is sampled.
- **ISSUE:**
  - Assert wt_i_stb (write) or rd_i_stb (read), registered. Never assert both.
  - Present RD_ADR or WT_ADR/WT_DATA from the latched values; these stay stable from ISSUE entry until IDLE.
  - When the matching i_ack is sampled high, deassert stb next cycle and go to WAIT.
- **WAIT:**
  - Write: on sampling wt_o_stb high, pulse c_done[idx] next cycle with c_err=0, then go to IDLE.
  - Read: on sampling rd_o_stb high, register RD_DATA into c_rdata, pulse c_done[idx] next cycle, then go to IDLE.
- **Watchdog:**
  - Cleared on ISSUE entry; increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT: drop stb, pulse c_done[idx] and c_err next cycle, set c_rdata=0, go to IDLE.
  - If completion and timeout coincide in the same cycle, completion wins and c_err=0.
- **Stray completions:** an o_stb arriving in IDLE or ISSUE (e.g. late after an abort) is acknowledged and discarded. It does not change c_rdata or c_done.
- **Back-to-back:** a new grant may occur in the same cycle c_done is pulsed, since the state is IDLE then.
- **Pointer on non-grant:** the pointer does not change when no request is present.
- **Wrong-type ack:** an i_ack of the wrong type (rd_i_ack during a write) is ignored.
- **Request timing:** c_req deasserted before c_gnt is simply not served. No request queue exists beyond the latched transaction.

Test Plan:
- **Single write:** client 0 writes adr=0x400123, data=0xBEEF; controller acks 2 cycles after stb. Expect: c_gnt[0] 1 cycle after c_req, wt_i_stb held until ack, WT_ADR/WT_DATA stable throughout, c_done[0] 1 cycle after wt_o_stb, c_err=0.
- **Single read:** client 2 reads adr=0x000010; model returns 0x1234 with rd_o_stb. Expect: c_rdata=0x1234 with c_done[2], and rd_o_ack high in the rd_o_stb cycle.
- **Fairness:** all 3 clients hold c_req continuously from reset. Expect grant order 0,1,2,0,1,2. Then clients 1 and 2 only, last granted=1: next grant is 2.
- **Timeout:** TIMEOUT=8, controller never acks. Expect: stb drops, c_done and c_err pulse exactly 9 cycles after ISSUE entry, then the next request proceeds normally. A late rd_o_stb after the abort must be discarded.
- **Completion at timeout edge:** wt_o_stb arrives in the cycle the watchdog hits TIMEOUT. Expect c_done with c_err=0.
- **Reset mid-transaction:** RST asserted in WAIT. Expect: all outputs 0 next cycle, no c_done, pointer reset so client 0 wins the next contention.
